video_timing_gen: RTL and testbench

Parametrised horizontal and vertical raster timing generator, the successor to the fixed 455-count horizontal chain. Runs on the system drive clock and advances one pixel per pixel-clock-enable strobe. Produces H/V counts, one-pixel line-end and frame-end reset pulses, sync and blank windows, and a genlock-style realignment load. Video, sync-mix and game-object logic all consume these outputs.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/timing_axis.sv | 72 +++++++
 rtl/video_timing_gen.sv | 100 ++++++++++
 tb/tb_video_timing_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster constants and window type for video_timing_gen
package video_timing_pkg;

    localparam int PONG_H_TOTAL       = 455;
    localparam int PONG_V_TOTAL       = 262;
    localparam int PONG_H_BLANK_START = 0;
    localparam int PONG_H_BLANK_END   = 80;
    localparam int PONG_H_SYNC_START  = 32;
    localparam int PONG_H_SYNC_END    = 64;
    localparam int PONG_V_BLANK_START = 0;
    localparam int PONG_V_BLANK_END   = 16;
    localparam int PONG_V_SYNC_START  = 4;
    localparam int PONG_V_SYNC_END    = 8;

    // Half-open window [start, stop); start == stop is never active.
    typedef struct packed {
        logic [31:0] start;
        logic [31:0] stop;
    } window_t;

    function automatic window_t make_window(input int first, input int past);
        window_t w;
        w.start = 32'(first);
        w.stop  = 32'(past);
        return w;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one raster axis: wrapping counter with load, next-count decodes
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int      W     = 9,
    parameter int      TOTAL = PONG_H_TOTAL,
    parameter window_t BLANK = make_window(PONG_H_BLANK_START, PONG_H_BLANK_END),
    parameter window_t SYNC  = make_window(PONG_H_SYNC_START, PONG_H_SYNC_END)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         term_next,
    output logic         blank_next,
    output logic         sync_next,
    output logic         wrap
);

    if (longint'(TOTAL) > (longint'(1) << W)) begin : g_bad_range
        $fatal(1, "timing_axis: TOTAL does not fit the counter width");
    end
    if (TOTAL < 2) begin : g_bad_total
        $fatal(1, "timing_axis: TOTAL must be at least 2");
    end
    if (int'(BLANK.start) > int'(BLANK.stop) || int'(BLANK.stop) > TOTAL) begin : g_bad_blank
        $fatal(1, "timing_axis: blank window outside 0..TOTAL");
    end
    if (int'(SYNC.start) > int'(SYNC.stop) || int'(SYNC.stop) > TOTAL) begin : g_bad_sync
        $fatal(1, "timing_axis: sync window outside 0..TOTAL");
    end

    // One extra bit so TOTAL == 2**W and window edges at TOTAL stay representable.
    localparam logic [W:0] TOT  = (W+1)'(TOTAL);
    localparam logic [W:0] LAST = TOT - (W+1)'(1);
    localparam logic [W:0] BS   = (W+1)'(BLANK.start);
    localparam logic [W:0] BE   = (W+1)'(BLANK.stop);
    localparam logic [W:0] SS   = (W+1)'(SYNC.start);
    localparam logic [W:0] SE   = (W+1)'(SYNC.stop);

    logic [W-1:0] count_next;
    logic [W:0]   next_x;

    always_comb begin
        count_next = count;
        if (!resetn) begin
            count_next = '0;
        end else if (load) begin
            count_next = ({1'b0, load_value} >= TOT) ? '0 : load_value;
        end else if (step) begin
            count_next = ({1'b0, count} == LAST) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Decodes look at the next count so the registered flags line up with count.
    assign next_x     = {1'b0, count_next};
    assign term_next  = (next_x == LAST);
    assign blank_next = (next_x >= BS) && (next_x < BE);
    assign sync_next  = (next_x >= SS) && (next_x < SE);
    assign wrap       = step && ({1'b0, count} == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised H/V raster timing generator with genlock load
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HW            = 9,
    parameter int VW            = 9,
    parameter int H_TOTAL       = PONG_H_TOTAL,
    parameter int V_TOTAL       = PONG_V_TOTAL,
    parameter int H_BLANK_START = PONG_H_BLANK_START,
    parameter int H_BLANK_END   = PONG_H_BLANK_END,
    parameter int H_SYNC_START  = PONG_H_SYNC_START,
    parameter int H_SYNC_END    = PONG_H_SYNC_END,
    parameter int V_BLANK_START = PONG_V_BLANK_START,
    parameter int V_BLANK_END   = PONG_V_BLANK_END,
    parameter int V_SYNC_START  = PONG_V_SYNC_START,
    parameter int V_SYNC_END    = PONG_V_SYNC_END
) (
    input  logic          CLK_DRV,
    input  logic          RESET_N,
    input  logic          PIX_CE,
    input  logic          ALIGN,
    input  logic [HW-1:0] ALIGN_H,
    input  logic [VW-1:0] ALIGN_V,
    output logic [HW-1:0] HCOUNT,
    output logic [VW-1:0] VCOUNT,
    output logic          HRESET,
    output logic          HRESET_N,
    output logic          VRESET,
    output logic          VRESET_N,
    output logic          HBLANK,
    output logic          VBLANK,
    output logic          HSYNC_N,
    output logic          VSYNC_N,
    output logic          CSYNC_N
);

    logic load;
    logic h_term, h_blank, h_sync, h_wrap;
    logic v_term, v_blank, v_sync;

    // A load wins over the V step inside the axis, so ALIGN never double-steps V.
    assign load = ALIGN && PIX_CE;

    timing_axis #(
        .W     (HW),
        .TOTAL (H_TOTAL),
        .BLANK (make_window(H_BLANK_START, H_BLANK_END)),
        .SYNC  (make_window(H_SYNC_START, H_SYNC_END))
    ) u_h_axis (
        .clk        (CLK_DRV),
        .resetn     (RESET_N),
        .step       (PIX_CE),
        .load       (load),
        .load_value (ALIGN_H),
        .count      (HCOUNT),
        .term_next  (h_term),
        .blank_next (h_blank),
        .sync_next  (h_sync),
        .wrap       (h_wrap)
    );

    timing_axis #(
        .W     (VW),
        .TOTAL (V_TOTAL),
        .BLANK (make_window(V_BLANK_START, V_BLANK_END)),
        .SYNC  (make_window(V_SYNC_START, V_SYNC_END))
    ) u_v_axis (
        .clk        (CLK_DRV),
        .resetn     (RESET_N),
        .step       (h_wrap && PIX_CE),
        .load       (load),
        .load_value (ALIGN_V),
        .count      (VCOUNT),
        .term_next  (v_term),
        .blank_next (v_blank),
        .sync_next  (v_sync),
        .wrap       ()
    );

    always_ff @(posedge CLK_DRV) begin
        if (!RESET_N) begin
            HRESET   <= 1'b0;
            HRESET_N <= 1'b1;
            VRESET   <= 1'b0;
            VRESET_N <= 1'b1;
        end else begin
            HRESET   <= h_term;
            HRESET_N <= !h_term;
            VRESET   <= h_term && v_term;
            VRESET_N <= !(h_term && v_term);
        end
        // Under reset the axis next-counts are forced to 0, giving the count-0 decode.
        HBLANK  <= h_blank;
        VBLANK  <= v_blank;
        HSYNC_N <= !h_sync;
        VSYNC_N <= !v_sync;
        CSYNC_N <= !(h_sync ^ v_sync);
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized and directed checks of video_timing_gen against a raster model
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_ce, a_al, b_ce, b_al;
    logic [8:0] a_ah, a_av;
    logic [9:0] b_ah, b_av;
    logic [8:0] a_hc, a_vc;
    logic [9:0] b_hc, b_vc;
    logic a_hr, a_hrn, a_vr, a_vrn, a_hb, a_vb, a_hsn, a_vsn, a_csn;
    logic b_hr, b_hrn, b_vr, b_vrn, b_hb, b_vb, b_hsn, b_vsn, b_csn;

    int checks = 0;
    int errors = 0;
    int ah_m = 0, av_m = 0, bh_m = 0, bv_m = 0;
    int n;

    video_timing_gen dut_a (
        .CLK_DRV(clk), .RESET_N(rst_n), .PIX_CE(a_ce), .ALIGN(a_al),
        .ALIGN_H(a_ah), .ALIGN_V(a_av), .HCOUNT(a_hc), .VCOUNT(a_vc),
        .HRESET(a_hr), .HRESET_N(a_hrn), .VRESET(a_vr), .VRESET_N(a_vrn),
        .HBLANK(a_hb), .VBLANK(a_vb), .HSYNC_N(a_hsn), .VSYNC_N(a_vsn),
        .CSYNC_N(a_csn)
    );

    video_timing_gen #(.HW(10), .VW(10), .H_TOTAL(800), .V_TOTAL(525)) dut_b (
        .CLK_DRV(clk), .RESET_N(rst_n), .PIX_CE(b_ce), .ALIGN(b_al),
        .ALIGN_H(b_ah), .ALIGN_V(b_av), .HCOUNT(b_hc), .VCOUNT(b_vc),
        .HRESET(b_hr), .HRESET_N(b_hrn), .VRESET(b_vr), .VRESET_N(b_vrn),
        .HBLANK(b_hb), .VBLANK(b_vb), .HSYNC_N(b_hsn), .VSYNC_N(b_vsn),
        .CSYNC_N(b_csn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic inwin(input int x, input int s, input int e);
        return (x >= s) && (x < e);
    endfunction

    // Raster position as a pair of integers, advanced by the counting rules.
    task automatic model_step(input int ht, input int vt, input logic rst, input logic ce,
                              input logic al, input int ah, input int av,
                              inout int h, inout int v);
        if (!rst) begin
            h = 0;
            v = 0;
        end else if (ce) begin
            if (al) begin
                h = (ah >= ht) ? 0 : ah;
                v = (av >= vt) ? 0 : av;
            end else if (h == ht - 1) begin
                h = 0;
                v = (v + 1) % vt;
            end else begin
                h = h + 1;
            end
        end
    endtask

    task automatic check_outs(input string p, input int ht, input int vt, input int h, input int v,
                              input logic [31:0] hc, input logic [31:0] vc,
                              input logic hr, input logic hrn, input logic vr, input logic vrn,
                              input logic hb, input logic vb, input logic hsn, input logic vsn,
                              input logic csn);
        logic hs, vs, le, fe;
        hs = inwin(h, 32, 64);
        vs = inwin(v, 4, 8);
        le = (h == ht - 1);
        fe = le && (v == vt - 1);
        chk({p, " hcount"},   hc, 32'(h));
        chk({p, " vcount"},   vc, 32'(v));
        chk({p, " hreset"},   32'(hr),  32'(le));
        chk({p, " hreset_n"}, 32'(hrn), 32'(!le));
        chk({p, " vreset"},   32'(vr),  32'(fe));
        chk({p, " vreset_n"}, 32'(vrn), 32'(!fe));
        chk({p, " hblank"},   32'(hb),  32'(inwin(h, 0, 80)));
        chk({p, " vblank"},   32'(vb),  32'(inwin(v, 0, 16)));
        chk({p, " hsync_n"},  32'(hsn), 32'(!hs));
        chk({p, " vsync_n"},  32'(vsn), 32'(!vs));
        chk({p, " csync_n"},  32'(csn), 32'(!(hs ^ vs)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(455, 262, rst_n, a_ce, a_al, int'(a_ah), int'(a_av), ah_m, av_m);
        model_step(800, 525, rst_n, b_ce, b_al, int'(b_ah), int'(b_av), bh_m, bv_m);
        #1;
        check_outs("a", 455, 262, ah_m, av_m, 32'(a_hc), 32'(a_vc), a_hr, a_hrn, a_vr, a_vrn,
                   a_hb, a_vb, a_hsn, a_vsn, a_csn);
        check_outs("b", 800, 525, bh_m, bv_m, 32'(b_hc), 32'(b_vc), b_hr, b_hrn, b_vr, b_vrn,
                   b_hb, b_vb, b_hsn, b_vsn, b_csn);
    endtask

    task automatic align_a(input int h, input int v);
        a_ce = 1'b1; a_al = 1'b1; a_ah = 9'(h); a_av = 9'(v);
        tick();
        a_al = 1'b0; a_ce = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_ce = 1'b0; a_al = 1'b0; a_ah = '0; a_av = '0;
        b_ce = 1'b0; b_al = 1'b0; b_ah = '0; b_av = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-frame.
        align_a(199, 100);
        a_ce = 1'b1; tick(); a_ce = 1'b0;
        chk("pre_reset_hcount", 32'(a_hc), 32'd200);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_reset_hcount", 32'(a_hc), 32'd0);
        chk("mid_reset_hblank", 32'(a_hb), 32'd1);

        // Random strobes, aligns (including out-of-range loads) and rare resets.
        repeat (3000) begin
            a_ce  = 1'($urandom_range(0, 1));
            b_ce  = 1'($urandom_range(0, 1));
            a_al  = ($urandom_range(0, 63) == 0);
            b_al  = ($urandom_range(0, 63) == 0);
            a_ah  = 9'($urandom_range(0, 511));
            a_av  = 9'($urandom_range(0, 511));
            b_ah  = 10'($urandom_range(0, 1023));
            b_av  = 10'($urandom_range(0, 1023));
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        a_al = 1'b0; b_al = 1'b0; a_ce = 1'b0; b_ce = 1'b0; rst_n = 1'b1;

        // From reset with a strobe every 4th cycle over two lines.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 4 * 455 * 2 + 8; i++) begin
            a_ce = ((i % 4) == 3);
            tick();
            if (i == 4 * 455 - 1) begin
                chk("line1_hcount", 32'(a_hc), 32'd0);
                chk("line1_vcount", 32'(a_vc), 32'd1);
            end
        end
        a_ce = 1'b0;

        // Frame wrap.
        align_a(453, 261);
        a_ce = 1'b1; tick();
        chk("frame_end_vreset", 32'(a_vr), 32'd1);
        chk("frame_end_hreset", 32'(a_hr), 32'd1);
        tick(); a_ce = 1'b0;
        chk("frame_wrap_vcount", 32'(a_vc), 32'd0);
        chk("frame_wrap_vreset", 32'(a_vr), 32'd0);

        // Aligns: plain, without strobe, out of range, landing on the line end.
        align_a(100, 50);
        chk("align_hblank", 32'(a_hb), 32'd0);
        chk("align_vblank", 32'(a_vb), 32'd0);
        a_al = 1'b1; a_ah = 9'd7; a_av = 9'd7; tick(); tick(); a_al = 1'b0;
        chk("align_no_ce_hcount", 32'(a_hc), 32'd100);
        align_a(500, 3);
        chk("align_oob_hcount", 32'(a_hc), 32'd0);
        align_a(454, 20);
        chk("align_end_hreset", 32'(a_hr), 32'd1);
        a_ce = 1'b1; tick(); a_ce = 1'b0;
        chk("align_end_vcount", 32'(a_vc), 32'd21);

        // Reset beats a same-cycle align.
        a_ce = 1'b1; a_al = 1'b1; a_ah = 9'd300; a_av = 9'd200; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; a_al = 1'b0; a_ce = 1'b0;
        chk("reset_over_align_h", 32'(a_hc), 32'd0);
        chk("reset_over_align_v", 32'(a_vc), 32'd0);

        // 800x525 instance: line period and strobes from line 520 to frame end.
        b_ce = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!b_hr && n < 2000);
        chk("b_first_line_end", 32'(n), 32'd799);
        n = 0;
        do begin tick(); n++; end while (!b_hr && n < 2000);
        chk("b_line_period", 32'(n), 32'd800);
        b_al = 1'b1; b_ah = 10'd0; b_av = 10'd520; tick(); b_al = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!b_vr && n < 5000);
        chk("b_frame_tail", 32'(n), 32'd3999);
        tick();
        chk("b_frame_wrap_v", 32'(b_vc), 32'd0);
        b_ce = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
